// File: rtl/cog_hub_port.sv
// Cog-side hub port: latches one cog request, drives it onto the hub OR-mux
// during this cog's slot, then waits for an ack or times out.
`timescale 1ns/1ps

module cog_hub_port (
    input  logic        clk_cog,
    input  logic        nres,
    input  logic        ena_bus,
    input  logic        sel,
    input  logic        req,
    input  logic        req_r,
    input  logic        req_w,
    input  logic [1:0]  req_s,
    input  logic [15:0] req_a,
    input  logic [31:0] req_d,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rd_q,
    output logic        rd_c,
    output logic        bus_r,
    output logic        bus_e,
    output logic        bus_w,
    output logic [1:0]  bus_s,
    output logic [15:0] bus_a,
    output logic [31:0] bus_d,
    input  logic        bus_ack,
    input  logic [31:0] bus_q,
    input  logic        bus_c
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        ISSUED = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic        r_reqR;
    logic        r_reqW;
    logic [1:0]  r_reqS;
    logic [15:0] r_reqA;
    logic [31:0] r_reqD;
    logic [1:0]  r_ackCnt;
    logic        r_done;
    logic        r_err;
    logic [31:0] r_rdQ;
    logic        r_rdC;

    logic        w_latch;
    logic        w_issue;
    logic        w_capture;
    logic        w_timeout;
    logic        w_count;
    logic        w_drive;

    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_latch     = 1'b0;
        w_issue     = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        w_count     = 1'b0;
        case (r_state)
            IDLE: begin
                if (req) begin
                    w_latch     = 1'b1;
                    w_nextState = PEND;
                end
            end
            PEND: begin
                if (ena_bus && sel) begin
                    w_issue     = 1'b1;
                    w_nextState = ISSUED;
                end
            end
            ISSUED: begin
                // Ack wins over timeout when both land on the same strobe.
                if (ena_bus) begin
                    if (bus_ack) begin
                        w_capture   = 1'b1;
                        w_nextState = IDLE;
                    end else if (r_ackCnt == 2'd3) begin
                        w_timeout   = 1'b1;
                        w_nextState = IDLE;
                    end else begin
                        w_count     = 1'b1;
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            r_reqR   <= 1'b0;
            r_reqW   <= 1'b0;
            r_reqS   <= 2'b00;
            r_reqA   <= 16'h0000;
            r_reqD   <= 32'h0000_0000;
            r_ackCnt <= 2'd0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_rdQ    <= 32'h0000_0000;
            r_rdC    <= 1'b0;
        end else begin
            if (w_latch) begin
                r_reqR <= req_r;
                r_reqW <= req_w;
                r_reqS <= req_s;
                r_reqA <= req_a;
                r_reqD <= req_d;
            end
            if (w_issue) begin
                r_ackCnt <= 2'd0;
            end else if (w_count) begin
                r_ackCnt <= r_ackCnt + 2'd1;
            end
            if (w_capture) begin
                r_rdQ <= bus_q;
                r_rdC <= bus_c;
            end
            r_done <= w_capture | w_timeout;
            r_err  <= w_timeout;
        end
    end

    // Outside our PEND slot every field is zero so the hub OR-mux stays clean.
    assign w_drive = (r_state == PEND) && sel;

    assign bus_e = w_drive;
    assign bus_r = w_drive & r_reqR;
    assign bus_w = w_drive & r_reqW;
    assign bus_s = w_drive ? r_reqS : 2'b00;
    assign bus_a = w_drive ? r_reqA : 16'h0000;
    assign bus_d = w_drive ? r_reqD : 32'h0000_0000;

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign err  = r_err;
    assign rd_q = r_rdQ;
    assign rd_c = r_rdC;

endmodule

// File: tb/tb_cog_hub_port.sv
// Directed bench for cog_hub_port: read, write, timeout, sys op,
// back-to-back, reset abort and stray-ack scenarios.
`timescale 1ns/1ps

module tb_cog_hub_port;

    logic        clk_cog = 1'b0;
    logic        nres;
    logic        ena_bus;
    logic        sel;
    logic        req;
    logic        req_r;
    logic        req_w;
    logic [1:0]  req_s;
    logic [15:0] req_a;
    logic [31:0] req_d;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rd_q;
    logic        rd_c;
    logic        bus_r;
    logic        bus_e;
    logic        bus_w;
    logic [1:0]  bus_s;
    logic [15:0] bus_a;
    logic [31:0] bus_d;
    logic        bus_ack;
    logic [31:0] bus_q;
    logic        bus_c;

    int vecCount  = 0;
    int missCount = 0;

    cog_hub_port dut (
        .clk_cog (clk_cog),
        .nres    (nres),
        .ena_bus (ena_bus),
        .sel     (sel),
        .req     (req),
        .req_r   (req_r),
        .req_w   (req_w),
        .req_s   (req_s),
        .req_a   (req_a),
        .req_d   (req_d),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .rd_q    (rd_q),
        .rd_c    (rd_c),
        .bus_r   (bus_r),
        .bus_e   (bus_e),
        .bus_w   (bus_w),
        .bus_s   (bus_s),
        .bus_a   (bus_a),
        .bus_d   (bus_d),
        .bus_ack (bus_ack),
        .bus_q   (bus_q),
        .bus_c   (bus_c)
    );

    always #5 clk_cog = ~clk_cog;

    // Advance one edge and settle; inputs set afterwards apply to the next edge.
    task automatic tick();
        @(posedge clk_cog);
        #1;
    endtask

    task automatic test_reset();
        nres = 1'b0; ena_bus = 1'b1; sel = 1'b1; req = 1'b0;
        req_r = 1'b0; req_w = 1'b0; req_s = 2'b00; req_a = 16'h0; req_d = 32'h0;
        bus_ack = 1'b0; bus_q = 32'h0; bus_c = 1'b0;
        tick(); tick();
        vecCount++; if (busy !== 1'b0) begin missCount++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        vecCount++; if (done !== 1'b0 || err !== 1'b0) begin missCount++; $display("[TB] FAIL reset_done_err got %b%b want 00", done, err); end
        vecCount++; if (rd_q !== 32'h0 || rd_c !== 1'b0) begin missCount++; $display("[TB] FAIL reset_rd got %h/%b want 0/0", rd_q, rd_c); end
        vecCount++; if (bus_e !== 1'b0 || bus_a !== 16'h0 || bus_d !== 32'h0) begin missCount++; $display("[TB] FAIL reset_bus got e=%b a=%h d=%h want zeros", bus_e, bus_a, bus_d); end
        sel = 1'b0;
        nres = 1'b1;
        tick();
    endtask

    task automatic test_long_read();
        req = 1'b1; req_r = 1'b1; req_w = 1'b0; req_s = 2'b10; req_a = 16'h1234; req_d = 32'h0;
        ena_bus = 1'b1; sel = 1'b0;
        tick();
        req = 1'b0;
        vecCount++; if (busy !== 1'b1) begin missCount++; $display("[TB] FAIL read_pend_busy got %b want 1", busy); end
        vecCount++; if (bus_a !== 16'h0 || bus_e !== 1'b0) begin missCount++; $display("[TB] FAIL read_nosel_bus got a=%h e=%b want 0/0", bus_a, bus_e); end
        tick(); tick();
        sel = 1'b1;
        #1;
        vecCount++; if (bus_a !== 16'h1234 || bus_e !== 1'b1 || bus_r !== 1'b1 || bus_s !== 2'b10) begin missCount++; $display("[TB] FAIL read_sel_bus got a=%h e=%b r=%b s=%b want 1234/1/1/10", bus_a, bus_e, bus_r, bus_s); end
        tick();
        vecCount++; if (bus_a !== 16'h0 || bus_e !== 1'b0 || bus_r !== 1'b0) begin missCount++; $display("[TB] FAIL read_issued_sel_bus got a=%h e=%b r=%b want zeros", bus_a, bus_e, bus_r); end
        sel = 1'b0;
        tick();
        vecCount++; if (done !== 1'b0 || busy !== 1'b1) begin missCount++; $display("[TB] FAIL read_wait got done=%b busy=%b want 0/1", done, busy); end
        bus_ack = 1'b1; bus_q = 32'hDEADBEEF; bus_c = 1'b1;
        tick();
        bus_ack = 1'b0;
        vecCount++; if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin missCount++; $display("[TB] FAIL read_done got done=%b err=%b busy=%b want 1/0/0", done, err, busy); end
        vecCount++; if (rd_q !== 32'hDEADBEEF || rd_c !== 1'b1) begin missCount++; $display("[TB] FAIL read_data got %h/%b want deadbeef/1", rd_q, rd_c); end
        tick();
        vecCount++; if (done !== 1'b0 || err !== 1'b0) begin missCount++; $display("[TB] FAIL read_done_pulse got done=%b err=%b want 0/0", done, err); end
    endtask

    task automatic test_byte_write();
        req = 1'b1; req_r = 1'b0; req_w = 1'b1; req_s = 2'b00; req_a = 16'h0040; req_d = 32'h000000A5;
        ena_bus = 1'b1; sel = 1'b0;
        tick();
        req_d = 32'hFFFF_FFFF; req_w = 1'b0;
        vecCount++; if (bus_w !== 1'b0 || bus_d !== 32'h0) begin missCount++; $display("[TB] FAIL write_nosel got w=%b d=%h want 0/0", bus_w, bus_d); end
        ena_bus = 1'b0; sel = 1'b1;
        #1;
        vecCount++; if (bus_w !== 1'b1 || bus_d !== 32'h000000A5 || bus_r !== 1'b0) begin missCount++; $display("[TB] FAIL write_sel got w=%b d=%h r=%b want 1/a5/0", bus_w, bus_d, bus_r); end
        tick(); tick();
        vecCount++; if (busy !== 1'b1 || bus_d !== 32'h000000A5) begin missCount++; $display("[TB] FAIL write_hold_pend got busy=%b d=%h want 1/a5", busy, bus_d); end
        ena_bus = 1'b1;
        tick();
        sel = 1'b0;
        vecCount++; if (bus_w !== 1'b0 || bus_d !== 32'h0) begin missCount++; $display("[TB] FAIL write_issued_bus got w=%b d=%h want 0/0", bus_w, bus_d); end
        bus_ack = 1'b1; bus_q = 32'h11112222; bus_c = 1'b0;
        tick();
        bus_ack = 1'b0;
        vecCount++; if (done !== 1'b1 || err !== 1'b0 || rd_q !== 32'h11112222) begin missCount++; $display("[TB] FAIL write_done got done=%b err=%b q=%h want 1/0/11112222", done, err, rd_q); end
        tick();
    endtask

    task automatic test_timeout();
        req = 1'b1; req_r = 1'b1; req_w = 1'b0; req_s = 2'b01; req_a = 16'h0100;
        ena_bus = 1'b1; sel = 1'b0;
        tick();
        req = 1'b0; sel = 1'b1;
        tick();
        sel = 1'b0; bus_ack = 1'b0; bus_q = 32'hFFFF_FFFF; bus_c = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            vecCount++; if (done !== 1'b0 || busy !== 1'b1) begin missCount++; $display("[TB] FAIL timeout_wait%0d got done=%b busy=%b want 0/1", i, done, busy); end
        end
        tick();
        vecCount++; if (done !== 1'b1 || err !== 1'b1 || busy !== 1'b0) begin missCount++; $display("[TB] FAIL timeout_done got done=%b err=%b busy=%b want 1/1/0", done, err, busy); end
        vecCount++; if (rd_q !== 32'h11112222 || rd_c !== 1'b0) begin missCount++; $display("[TB] FAIL timeout_rd got %h/%b want 11112222/0", rd_q, rd_c); end
        tick();
        vecCount++; if (done !== 1'b0 || err !== 1'b0) begin missCount++; $display("[TB] FAIL timeout_clear got done=%b err=%b want 0/0", done, err); end
    endtask

    task automatic test_back_to_back();
        bus_c = 1'b1;
        req = 1'b1; req_r = 1'b0; req_w = 1'b0; req_s = 2'b11; req_a = 16'h0004; req_d = 32'h0;
        ena_bus = 1'b1; sel = 1'b0;
        tick();
        req = 1'b0; sel = 1'b1;
        #1;
        vecCount++; if (bus_s !== 2'b11 || bus_a !== 16'h0004) begin missCount++; $display("[TB] FAIL sys_bus got s=%b a=%h want 11/0004", bus_s, bus_a); end
        tick();
        sel = 1'b0; bus_ack = 1'b1; bus_q = 32'h3; bus_c = 1'b0;
        tick();
        bus_ack = 1'b0;
        vecCount++; if (done !== 1'b1 || err !== 1'b0 || rd_q !== 32'h3 || rd_c !== 1'b0) begin missCount++; $display("[TB] FAIL sys_done got done=%b err=%b q=%h c=%b want 1/0/3/0", done, err, rd_q, rd_c); end
        req = 1'b1; req_r = 1'b1; req_s = 2'b10; req_a = 16'hABCD;
        tick();
        req = 1'b0;
        vecCount++; if (busy !== 1'b1 || done !== 1'b0) begin missCount++; $display("[TB] FAIL b2b_accept got busy=%b done=%b want 1/0", busy, done); end
        sel = 1'b1;
        #1;
        vecCount++; if (bus_a !== 16'hABCD) begin missCount++; $display("[TB] FAIL b2b_bus got a=%h want abcd", bus_a); end
        tick();
        sel = 1'b0; bus_ack = 1'b1; bus_q = 32'hCAFEF00D; bus_c = 1'b1;
        tick();
        bus_ack = 1'b0;
        vecCount++; if (done !== 1'b1 || rd_q !== 32'hCAFEF00D || rd_c !== 1'b1) begin missCount++; $display("[TB] FAIL b2b_done got done=%b q=%h c=%b want 1/cafef00d/1", done, rd_q, rd_c); end
        tick();
    endtask

    task automatic test_reset_abort();
        req = 1'b1; req_r = 1'b1; req_w = 1'b1; req_s = 2'b10; req_a = 16'h7777; req_d = 32'h1;
        ena_bus = 1'b1; sel = 1'b0;
        tick();
        req = 1'b0; sel = 1'b1;
        #2;
        nres = 1'b0;
        #1;
        vecCount++; if (bus_e !== 1'b0 || bus_a !== 16'h0 || bus_w !== 1'b0 || busy !== 1'b0) begin missCount++; $display("[TB] FAIL rst_pend_bus got e=%b a=%h w=%b busy=%b want zeros", bus_e, bus_a, bus_w, busy); end
        nres = 1'b1;
        req = 1'b1; sel = 1'b0;
        tick();
        req = 1'b0; sel = 1'b1;
        tick();
        sel = 1'b0;
        vecCount++; if (busy !== 1'b1) begin missCount++; $display("[TB] FAIL rst_reach_issued got busy=%b want 1", busy); end
        #2;
        nres = 1'b0;
        #1;
        vecCount++; if (busy !== 1'b0 || done !== 1'b0 || rd_q !== 32'h0 || rd_c !== 1'b0) begin missCount++; $display("[TB] FAIL rst_issued got busy=%b done=%b q=%h c=%b want 0/0/0/0", busy, done, rd_q, rd_c); end
        bus_ack = 1'b1; bus_q = 32'h9999_9999;
        tick();
        vecCount++; if (done !== 1'b0) begin missCount++; $display("[TB] FAIL rst_no_done got %b want 0", done); end
        bus_ack = 1'b0;
        nres = 1'b1;
        req = 1'b1; req_w = 1'b0; req_a = 16'h2222;
        tick();
        req = 1'b0;
        vecCount++; if (busy !== 1'b1) begin missCount++; $display("[TB] FAIL rst_first_req got busy=%b want 1", busy); end
        sel = 1'b1;
        tick();
        sel = 1'b0; bus_ack = 1'b1; bus_q = 32'h55AA_55AA; bus_c = 1'b0;
        tick();
        bus_ack = 1'b0;
        vecCount++; if (done !== 1'b1 || err !== 1'b0 || rd_q !== 32'h55AA_55AA) begin missCount++; $display("[TB] FAIL rst_after_done got done=%b err=%b q=%h want 1/0/55aa55aa", done, err, rd_q); end
        tick();
    endtask

    task automatic test_stray_ack();
        ena_bus = 1'b1; sel = 1'b0; bus_ack = 1'b1; bus_q = 32'h0BAD_BEEF; bus_c = 1'b1;
        tick(); tick();
        vecCount++; if (done !== 1'b0 || busy !== 1'b0 || rd_q !== 32'h55AA_55AA) begin missCount++; $display("[TB] FAIL stray_idle got done=%b busy=%b q=%h want 0/0/55aa55aa", done, busy, rd_q); end
        req = 1'b1; req_r = 1'b1; req_s = 2'b10; req_a = 16'h3030;
        tick();
        req = 1'b0;
        tick(); tick();
        vecCount++; if (done !== 1'b0 || busy !== 1'b1 || rd_q !== 32'h55AA_55AA) begin missCount++; $display("[TB] FAIL stray_pend got done=%b busy=%b q=%h want 0/1/55aa55aa", done, busy, rd_q); end
        bus_ack = 1'b0; sel = 1'b1;
        tick();
        sel = 1'b0; ena_bus = 1'b0; bus_ack = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        vecCount++; if (done !== 1'b0 || busy !== 1'b1 || rd_q !== 32'h55AA_55AA) begin missCount++; $display("[TB] FAIL stray_noena got done=%b busy=%b q=%h want 0/1/55aa55aa", done, busy, rd_q); end
        ena_bus = 1'b1;
        tick();
        bus_ack = 1'b0;
        vecCount++; if (done !== 1'b1 || err !== 1'b0 || rd_q !== 32'h0BAD_BEEF || rd_c !== 1'b1) begin missCount++; $display("[TB] FAIL stray_final got done=%b err=%b q=%h c=%b want 1/0/0badbeef/1", done, err, rd_q, rd_c); end
        tick();
    endtask

    initial begin
        test_reset();
        test_long_read();
        test_byte_write();
        test_timeout();
        test_back_to_back();
        test_reset_abort();
        test_stray_ack();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/cog_hub_port.md
COG_HUB_PORT -- requirements
Module: cog_hub_port

Interface
REQ-001 SHALL have clk_cog  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have nres  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ena_bus  input  1  hub bus strobe; the bus advances one slot per clk_cog edge with ena_bus=1.
REQ-004 SHALL have sel  input  1  this cog's bus_sel bit; 1 = this cog owns the current slot.
REQ-005 SHALL have req  input  1  cog request strobe, sampled only in IDLE.
REQ-006 SHALL have req_r, req_w  input  1 each  read/write qualifiers.
REQ-007 SHALL have req_s  input  2  size/op: 00 byte, 01 word, 10 long, 11 sys.
REQ-008 SHALL have req_a  input  16; req_d  input  32  hub address / write data or sys operand.
REQ-009 SHALL have busy  output  1  high in every state except IDLE.
REQ-010 SHALL have done  output  1  one-clk_cog pulse when an access completes.
REQ-011 SHALL have err  output  1  qualifies done: 1 = access timed out.
REQ-012 SHALL have rd_q  output  32; rd_c  output  1  captured bus_q / bus_c.
REQ-013 SHALL have bus_r, bus_e, bus_w  output  1 each; bus_s  output  2; bus_a  output  16; bus_d  output  32  request fields into the hub's OR-mux.
REQ-014 SHALL have bus_ack  input  1 (this cog's ack bit); bus_q  input  32; bus_c  input  1.

Function
REQ-015 SHALL implement states IDLE, PEND, ISSUED.
REQ-016 In IDLE, req=1 SHALL latch req_r/w/s/a/d into holding registers and move to PEND on the same edge; ena_bus irrelevant.
REQ-017 req SHALL be ignored while busy=1; holding registers SHALL stay stable from latch until return to IDLE.
REQ-018 bus_e/r/w/s/a/d SHALL be combinational: holding-register values when state=PEND and sel=1, else all-zero (OR-mux safe).
REQ-019 PEND with ena_bus=1 and sel=1 SHALL move to ISSUED and clear the ack timeout counter to 0.
REQ-020 PEND with sel=0 or ena_bus=0 SHALL hold PEND indefinitely.
REQ-021 ISSUED with ena_bus=1 and bus_ack=1 SHALL capture bus_q into rd_q, bus_c into rd_c, pulse done=1 with err=0 for exactly the next cycle, and return to IDLE.
REQ-022 ISSUED: 2-bit counter SHALL increment on each ena_bus=1 edge with bus_ack=0; nominal ack arrives on the 2nd ena_bus strobe after issue.
REQ-023 If counter reaches 3 with no ack, next ena_bus edge SHALL pulse done=1 with err=1, leave rd_q/rd_c unchanged, return to IDLE.
REQ-024 bus_ack=1 with ena_bus=0 SHALL be ignored; bus_ack in IDLE or PEND SHALL be ignored.
REQ-025 rd_q/rd_c SHALL hold their last captured value until the next successful capture.
REQ-026 err SHALL be 0 whenever done=0.
REQ-027 A new req in the same cycle done is high (state IDLE) SHALL be accepted: back-to-back accesses with no dead cycle.
REQ-028 sel and bus_ack simultaneously high in ISSUED SHALL not re-drive the bus (outputs zero outside PEND).

Reset
REQ-029 nres=0 SHALL asynchronously force state=IDLE, counter=0, busy=0, done=0, err=0, rd_q=0, rd_c=0, holding registers=0, all bus_* outputs=0.
REQ-030 Reset asserted in PEND or ISSUED SHALL abort the access without a done pulse; after release the block SHALL accept req on the first edge.

Verification
REQ-031 Long read: req, req_s=10, req_a=16'h1234; sel on 3rd strobe; bus_ack on 2nd strobe after with bus_q=32'hDEADBEEF -> bus_a=16'h1234 only during sel slot, rd_q=32'hDEADBEEF, done=1 err=0 one cycle.
REQ-032 Byte write: req_w=1, req_s=00, req_d=32'h000000A5 -> bus_w=1, bus_d=32'h000000A5 only while sel=1 in PEND; zero elsewhere.
REQ-033 Timeout: issue, hold bus_ack=0 for 4 strobes -> done=1 err=1 on 4th, rd_q unchanged, state IDLE.
REQ-034 Sys op: req_s=11, req_a=3'b100 (locknew), ack with bus_q=3, bus_c=0 -> rd_q=3, rd_c=0; back-to-back req during done accepted.
REQ-035 Reset in ISSUED: nres low mid-access -> all outputs 0 immediately, no done; new req after release completes normally.
REQ-036 Stray ack: bus_ack=1 in IDLE and PEND, and with ena_bus=0 in ISSUED -> no done, no rd_q change.
